// File: rtl/sm83_pkg.sv
// Shared defaults and vector types for the SM83 cycle sequencer.
package sm83_pkg;

    localparam int SM83_T_STATES = 4;
    localparam int SM83_M_CYCLES = 6;
    localparam int SM83_MCOUNT_W = $clog2(SM83_M_CYCLES);

    typedef logic [SM83_M_CYCLES-1:0] mcyc_t;
    typedef logic [SM83_T_STATES-1:0] tstate_t;
    typedef logic [SM83_MCOUNT_W-1:0] mcount_t;

    // Execution modes; bit 0 is the reset-mode flag, bit 1 the halt flag.
    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_RST  = 2'b01;
    localparam logic [1:0] MODE_HALT = 2'b10;

endpackage

// File: rtl/sm83_onehot_ring.sv
// One-hot rotator with enable and synchronous load back to bit 0.
module sm83_onehot_ring
    import sm83_pkg::*;
#(
    parameter int W = SM83_T_STATES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= W'(1);
        end else if (load) begin
            q <= W'(1);
        end else if (en) begin
            q <= {q[W-2:0], q[W-1]};
        end
    end

endmodule

// File: rtl/sm83_cycle_seq.sv
// SM83 M-cycle / T-state sequencer with halt/wake handling and overrun detection.
// Wait-state stretching is built only when SM83_SEQ_WAIT_EN is defined.
//
// mode      | meaning
// MODE_RST  | first instruction after reset (in_rst=1)
// MODE_RUN  | normal execution
// MODE_HALT | halted, m pinned to M1 until wake at T_LAST
module sm83_cycle_seq
    import sm83_pkg::*;
#(
    parameter int T_STATES = SM83_T_STATES,
    parameter int M_CYCLES = SM83_M_CYCLES,
    parameter int T_WAIT   = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        set_m1,
    input  logic                        wait_req,
    input  logic                        halt_req,
    input  logic                        wake,
    output logic [M_CYCLES-1:0]         m,
    output logic [T_STATES-1:0]         t,
    output logic [$clog2(M_CYCLES)-1:0] mcount,
    output logic                        phi,
    output logic                        in_rst,
    output logic                        in_halt,
    output logic                        overrun
);

    localparam int MW = $clog2(M_CYCLES);

    logic       stall;
    logic       t_last;
    logic       m_step;
    logic       m_load;
    logic       phi_next;
    logic [1:0] mode;

    assign t_last = t[T_STATES-1];

`ifdef SM83_SEQ_WAIT_EN
    assign stall = t[T_WAIT] & wait_req;
`else
    logic unused_wait_req;
    assign unused_wait_req = wait_req;
    assign stall = 1'b0;
`endif

    assign m_step = t_last & ~stall;
    assign m_load = m_step & (in_halt | set_m1);

    sm83_onehot_ring #(.W(T_STATES)) u_t_ring (
        .clk   (clk),
        .reset (reset),
        .en    (~stall),
        .load  (1'b0),
        .q     (t)
    );

    sm83_onehot_ring #(.W(M_CYCLES)) u_m_ring (
        .clk   (clk),
        .reset (reset),
        .en    (m_step),
        .load  (m_load),
        .q     (m)
    );

    // phi of the T-state the ring rotates into: T_LAST wraps to T1 (phi=1).
    always_comb begin
        phi_next = t[T_STATES-1];
        for (int i = 0; i < T_STATES/2 - 1; i++) begin
            phi_next = phi_next | t[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcount  <= '0;
            phi     <= 1'b1;
            mode    <= MODE_RST;
            overrun <= 1'b0;
        end else if (!stall) begin
            phi <= phi_next;
            if (t_last) begin
                if (m_load || m[M_CYCLES-1]) begin
                    mcount <= '0;
                end else begin
                    mcount <= mcount + MW'(1);
                end

                if (!in_halt && !set_m1 && m[M_CYCLES-1]) begin
                    overrun <= 1'b1;
                end

                // wake outranks halt_req; set_m1 is ignored while halted
                if (in_halt) begin
                    if (wake) begin
                        mode <= MODE_RUN;
                    end
                end else if (set_m1) begin
                    mode <= (halt_req && !wake) ? MODE_HALT : MODE_RUN;
                end
            end
        end
    end

    assign in_rst  = mode[0];
    assign in_halt = mode[1];

endmodule

// File: tb/tb_sm83_cycle_seq.sv
// Self-checking bench: default-geometry and 6T/8M/T_WAIT=2 sequencers against an index-based model.
module tb_sm83_cycle_seq;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic set_m1 = 1'b0;
    logic wait_req = 1'b0;
    logic halt_req = 1'b0;
    logic wake = 1'b0;

    logic [5:0] a_m;
    logic [3:0] a_t;
    logic [2:0] a_mc;
    logic       a_phi, a_rst, a_halt, a_ovr;

    logic [7:0] b_m;
    logic [5:0] b_t;
    logic [2:0] b_mc;
    logic       b_phi, b_rst, b_halt, b_ovr;

    int tests = 0;
    int fails = 0;

`ifdef SM83_SEQ_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    sm83_cycle_seq dut_a (
        .clk(clk), .reset(reset), .set_m1(set_m1), .wait_req(wait_req),
        .halt_req(halt_req), .wake(wake), .m(a_m), .t(a_t), .mcount(a_mc),
        .phi(a_phi), .in_rst(a_rst), .in_halt(a_halt), .overrun(a_ovr)
    );

    sm83_cycle_seq #(.T_STATES(6), .M_CYCLES(8), .T_WAIT(2)) dut_b (
        .clk(clk), .reset(reset), .set_m1(set_m1), .wait_req(wait_req),
        .halt_req(halt_req), .wake(wake), .m(b_m), .t(b_t), .mcount(b_mc),
        .phi(b_phi), .in_rst(b_rst), .in_halt(b_halt), .overrun(b_ovr)
    );

    // Behavioural model: T and M positions kept as plain integer indices.
    int tidx[2];
    int midx[2];
    bit mrst[2];
    bit mhalt[2];
    bit movr[2];

    function automatic int ts(int k); return (k == 0) ? 4 : 6; endfunction
    function automatic int mc(int k); return (k == 0) ? 6 : 8; endfunction
    function automatic int tw(int k); return (k == 0) ? 1 : 2; endfunction

    task automatic model_step(int k);
        bit last;
        bit stl;
        last = (tidx[k] == ts(k) - 1);
        stl  = WAIT_EN && (tidx[k] == tw(k)) && (wait_req === 1'b1);
        if (reset) begin
            tidx[k] = 0; midx[k] = 0;
            mrst[k] = 1; mhalt[k] = 0; movr[k] = 0;
        end else if (!stl) begin
            tidx[k] = (tidx[k] + 1) % ts(k);
            if (last) begin
                if (mhalt[k]) begin
                    midx[k] = 0;
                    if (wake) mhalt[k] = 0;
                end else if (set_m1) begin
                    midx[k] = 0;
                    mrst[k] = 0;
                    if (halt_req && !wake) mhalt[k] = 1;
                end else if (midx[k] == mc(k) - 1) begin
                    midx[k] = 0;
                    movr[k] = 1;
                end else begin
                    midx[k] = midx[k] + 1;
                end
            end
        end
    endtask

    task automatic compare(int k, logic [7:0] gm, logic [7:0] gt, logic [2:0] gmc,
                           logic gphi, logic grst, logic ghalt, logic govr);
        logic [7:0] em;
        logic [7:0] et;
        logic       ephi;
        em   = 8'd1 << midx[k];
        et   = 8'd1 << tidx[k];
        ephi = (tidx[k] < ts(k) / 2);
        tests++;
        if ({gm, gt, gmc, gphi, grst, ghalt, govr} !==
            {em, et, 3'(midx[k]), ephi, mrst[k], mhalt[k], movr[k]}) begin
            fails++;
            $display("FAIL model_dut%0d @%0t: got m=%h t=%h mc=%0d phi=%b rst=%b halt=%b ovr=%b, want m=%h t=%h mc=%0d phi=%b rst=%b halt=%b ovr=%b",
                     k, $time, gm, gt, gmc, gphi, grst, ghalt, govr,
                     em, et, midx[k], ephi, mrst[k], mhalt[k], movr[k]);
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        #1;
        compare(0, {2'b0, a_m}, {4'b0, a_t}, a_mc, a_phi, a_rst, a_halt, a_ovr);
        compare(1, b_m, {2'b0, b_t}, b_mc, b_phi, b_rst, b_halt, b_ovr);
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic wait_tlast();
        int n;
        n = 0;
        while (a_t !== 4'b1000 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            tests++;
            fails++;
            $display("FAIL sync_tlast: got t=%b, want 1000 within 20 clks", a_t);
        end
    endtask

    initial begin
        int cyc;
        int bad;
        logic [3:0] t_at4;

        // reset geometry, set_m1 at every T_LAST
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        set_m1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("geom_t%0d", i), a_t, 32'(1 << i));
            chk($sformatf("geom_phi%0d", i), a_phi, (i < 2) ? 1 : 0);
            chk($sformatf("geom_m%0d", i), a_m, 1);
            chk($sformatf("geom_rst%0d", i), a_rst, 1);
        end
        @(negedge clk);
        chk("rst_cleared", a_rst, 0);
        chk("first_m1_t", a_t, 1);

        // three-M-cycle instruction
        for (int i = 0; i < 12; i++) begin
            if (i % 4 == 0) begin
                chk($sformatf("multi_m%0d", i / 4), a_m, 32'(1 << (i / 4)));
                chk($sformatf("multi_mc%0d", i / 4), a_mc, i / 4);
            end
            set_m1 = (i == 11);
            @(negedge clk);
        end
        chk("multi_back_m", a_m, 1);
        chk("multi_back_mc", a_mc, 0);

        // wait stretching: wait_req high for 3 clks while t=2
        cyc = 0;
        t_at4 = '0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 4) t_at4 = a_t;
            wait_req = (cyc <= 3);
        end while (a_t !== 4'b0001 && cyc < 20);
        wait_req = 1'b0;
        chk("wait_mcycle_len", cyc, WAIT_EN ? 7 : 4);
        chk("wait_t_held", t_at4, WAIT_EN ? 2 : 1);

        // halt entry, hold for 10 M-cycles with set_m1 toggling
        wait_tlast();
        set_m1   = 1'b1;
        halt_req = 1'b1;
        @(negedge clk);
        chk("halt_entry", a_halt, 1);
        chk("halt_entry_m", a_m, 1);
        halt_req = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            set_m1 = (i % 2 == 1);
            @(negedge clk);
            if (a_m !== 6'd1 || a_halt !== 1'b1) bad++;
        end
        chk("halt_hold", bad, 0);
        set_m1 = 1'b0;
        wait_tlast();
        wake = 1'b1;
        @(negedge clk);
        chk("wake_exit", a_halt, 0);
        chk("wake_m", a_m, 1);
        wake = 1'b0;

        // wake outranks halt_req
        wait_tlast();
        set_m1   = 1'b1;
        halt_req = 1'b1;
        wake     = 1'b1;
        @(negedge clk);
        chk("halt_wake_both", a_halt, 0);
        halt_req = 1'b0;
        wake     = 1'b0;

        // overrun: no set_m1 for six M-cycles
        chk("ovr_clear", a_ovr, 0);
        set_m1 = 1'b0;
        for (int k = 0; k < 24; k++) begin
            if (k % 4 == 0) chk($sformatf("ovr_m%0d", k / 4), a_m, 32'(1 << (k / 4)));
            if (k == 23) chk("ovr_before_wrap", a_ovr, 0);
            @(negedge clk);
        end
        chk("ovr_wrap_m", a_m, 1);
        chk("ovr_wrap_mc", a_mc, 0);
        chk("ovr_set", a_ovr, 1);
        set_m1 = 1'b1;
        repeat (9) @(negedge clk);
        chk("ovr_sticky", a_ovr, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("ovr_reset", a_ovr, 0);
        chk("reset_rst", a_rst, 1);
        reset = 1'b0;

        // randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 199) == 0);
            set_m1   = ($urandom_range(0, 2) == 0);
            wait_req = ($urandom_range(0, 4) < 2);
            halt_req = ($urandom_range(0, 6) == 0);
            wake     = ($urandom_range(0, 4) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
